// File: rtl/btn_debounce_if.sv
// rtl/btn_debounce_if.sv - pushbutton pin and debounced event signals
interface btn_debounce_if;
    logic btn_in;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic btn_long;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long
    );
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - pushbutton synchronizer, debouncer and edge/long-press pulses
// Optional long-press detector compiled in with BTN_DEBOUNCE_LONGPRESS_EN.
module btn_debounce #(
    parameter int SYNC_STAGES    = 2,
    parameter int DEB_CYCLES     = 1_000_000,
    parameter int LONG_CYCLES    = 100_000_000,
    parameter int BTN_ACTIVE_LOW = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    btn_debounce_if.slave  btn
);

    localparam int              CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_SAT  = CW'(DEB_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    logic                   btn_pol;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          cnt_inc;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   level_q, level_d;

    assign btn_pol = (BTN_ACTIVE_LOW != 0) ? ~btn.btn_in : btn.btn_in;
    assign sync    = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            level_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_pol};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            level_q   <= level_d;
        end
    end

    // The sample that enters a WAIT state counts as the first stable one, so
    // an edge is accepted on the clock at which the count reaches DEB_CYCLES-1.
    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!sync) begin
                    state_d = IDLE;
                end else if (cnt_inc == CNT_LAST) begin
                    state_d = HELD;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD: begin
                if (!sync) state_d = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (sync) begin
                    state_d = HELD;
                end else if (cnt_inc == CNT_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
        level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    end

    assign btn.btn_level   = level_q;
    assign btn.btn_press   = press_q;
    assign btn.btn_release = release_q;

`ifdef BTN_DEBOUNCE_LONGPRESS_EN
    localparam int            LW       = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] HOLD_SAT = LW'(LONG_CYCLES);

    logic [LW-1:0] hold_q, hold_d;
    logic          long_q, long_d;

    // Release bounce keeps btn_level high, so the hold count keeps running through it.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (press_d) begin
            hold_d = '0;
        end else if (level_q && (hold_q != HOLD_SAT)) begin
            hold_d = hold_q + 1'b1;
            long_d = (hold_d == HOLD_SAT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign btn.btn_long = long_q;
`else
    assign btn.btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - scoreboard bench for btn_debounce
module tb_btn_debounce;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LONG = 10;
    localparam int LAT  = SYNC + DEB - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    btn_debounce_if bif();

    btn_debounce #(
        .SYNC_STAGES    (SYNC),
        .DEB_CYCLES     (DEB),
        .LONG_CYCLES    (LONG),
        .BTN_ACTIVE_LOW (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bif)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_press[$];
    int exp_rel[$];
    int exp_long[$];

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bif.btn_press === 1'b1) begin
            if (exp_press.size() == 0) chk("press_unexpected", cyc, -1);
            else chk("press_cycle", cyc, exp_press.pop_front());
        end
        if (bif.btn_release === 1'b1) begin
            if (exp_rel.size() == 0) chk("release_unexpected", cyc, -1);
            else chk("release_cycle", cyc, exp_rel.pop_front());
        end
        if (bif.btn_long === 1'b1) begin
            if (exp_long.size() == 0) chk("long_unexpected", cyc, -1);
            else chk("long_cycle", cyc, exp_long.pop_front());
        end
        if ((bif.btn_press | bif.btn_release) === 1'b1)
            chk("press_release_excl", 32'(bif.btn_press & bif.btn_release), 0);
    end

    task automatic drive(input logic v, output int k);
        bif.btn_in = v;
        k = cyc + 1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_level"},   32'(bif.btn_level),   0);
        chk({tag, "_press"},   32'(bif.btn_press),   0);
        chk({tag, "_release"}, 32'(bif.btn_release), 0);
        chk({tag, "_long"},    32'(bif.btn_long),    0);
    endtask

    task automatic press_hold(input int hold, input bit expect_long);
        int k;
        drive(1'b1, k);
        exp_press.push_back(k + LAT);
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
        if (expect_long) exp_long.push_back(k + LAT + LONG);
`endif
        wait_cyc(hold);
    endtask

    task automatic release_hold(input string tag);
        int k;
        drive(1'b0, k);
        exp_rel.push_back(k + LAT);
        wait_cyc(LAT + 3);
        chk({tag, "_level_after_release"}, 32'(bif.btn_level), 0);
    endtask

    initial begin
        int k;
        bif.btn_in = 1'b1;
        #1 rst_n = 1'b0;
        #3 chk_outputs_zero("reset");

        // Button held through reset: re-debounced from deassertion.
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k = cyc + 1;
        exp_press.push_back(k + LAT);
        wait_cyc(LAT + 2);
        chk("reset_held_level", 32'(bif.btn_level), 1);
        release_hold("reset_held");

        // Clean press held 20 cycles.
        press_hold(20, 1'b1);
        chk("clean_level", 32'(bif.btn_level), 1);
        release_hold("clean");

        // Press bounce: two short bursts before the steady rise.
        drive(1'b1, k); wait_cyc(3);
        drive(1'b0, k); wait_cyc(1);
        drive(1'b1, k); wait_cyc(3);
        drive(1'b0, k); wait_cyc(1);
        chk("bounce_level_low", 32'(bif.btn_level), 0);
        press_hold(LAT + 1, 1'b0);
        chk("bounce_level", 32'(bif.btn_level), 1);
        release_hold("bounce");

        // Release glitch: three low cycles do not release.
        press_hold(LAT + 2, 1'b1);
        chk("glitch_level_held", 32'(bif.btn_level), 1);
        drive(1'b0, k); wait_cyc(3);
        drive(1'b1, k); wait_cyc(3);
        chk("glitch_level_still", 32'(bif.btn_level), 1);
        release_hold("glitch");

        // Long press.
        press_hold(25, 1'b1);
        chk("long_level", 32'(bif.btn_level), 1);
        release_hold("long");

        // Reset mid-hold with the button released.
        press_hold(LAT + 3, 1'b0);
        chk("midhold_level", 32'(bif.btn_level), 1);
        drive(1'b0, k);
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("midhold_reset");
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(LONG + 2 * LAT);
        chk("midhold_level_after", 32'(bif.btn_level), 0);

        chk("press_pending",   exp_press.size(), 0);
        chk("release_pending", exp_rel.size(),   0);
        chk("long_pending",    exp_long.size(),  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of input synchronizer flops; legal range 2..4.
REQ-002 Parameter DEB_CYCLES, default 1_000_000, number of consecutive stable synchronized samples required to accept an edge; legal minimum 2.
REQ-003 Parameter LONG_CYCLES, default 100_000_000, number of cycles btn_level must stay high after btn_press before a long-press is flagged; legal minimum 1.
REQ-004 Parameter BTN_ACTIVE_LOW, default 0; when 1, btn_in is inverted before synchronization.
REQ-005 clk  input  1  single system clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 btn_in  input  1  raw asynchronous pushbutton pin.
REQ-008 btn_level  output  1  debounced button state, 1 = pressed.
REQ-009 btn_press  output  1  one-cycle pulse on accepted press.
REQ-010 btn_release  output  1  one-cycle pulse on accepted release.
REQ-011 btn_long  output  1  one-cycle pulse on long-press detection.

Function
REQ-012 Polarity-corrected btn_in shall pass through SYNC_STAGES flops; only the last stage output ("sync") feeds the logic.
REQ-013 The FSM shall have exactly four states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-014 Stability counter width shall be $clog2(DEB_CYCLES+1); cleared on every state change, incremented otherwise in PRESS_WAIT/RELEASE_WAIT, never wraps.
REQ-015 IDLE: sync=1 -> PRESS_WAIT; else stay.
REQ-016 PRESS_WAIT: sync=0 -> IDLE with no pulse; counter = DEB_CYCLES-1 with sync=1 -> HELD.
REQ-017 HELD: sync=0 -> RELEASE_WAIT; else stay.
REQ-018 RELEASE_WAIT: sync=1 -> HELD with no pulse; counter = DEB_CYCLES-1 with sync=0 -> IDLE.
REQ-019 btn_press shall be registered, high for exactly the first cycle of HELD entered from PRESS_WAIT; never on RELEASE_WAIT->HELD.
REQ-020 btn_release shall be registered, high for exactly the first cycle of IDLE entered from RELEASE_WAIT.
REQ-021 btn_level shall be 1 in HELD and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT.
REQ-022 Latency: btn_in stable from rising edge k onward shall produce btn_press (or btn_release) high in the cycle after edge k+SYNC_STAGES+DEB_CYCLES-1 (i.e. SYNC_STAGES+DEB_CYCLES edges).
REQ-023 A sync glitch shorter than DEB_CYCLES cycles shall produce no pulse and no btn_level change.
REQ-024 btn_press and btn_release shall never be high in the same cycle.

Reset
REQ-025 rst_n low shall asynchronously force state IDLE, all counters 0, synchronizer flops to the inactive (post-inversion 0) value, all outputs 0.
REQ-026 Reset asserted mid-press or mid-hold shall emit no btn_release or btn_long afterward; a still-held button after reset deassertion shall be re-debounced and produce btn_press per REQ-022.

Configuration
REQ-027 Macro BTN_DEBOUNCE_LONGPRESS_EN shall compile in the long-press logic.
REQ-028 With the macro defined: a hold counter of width $clog2(LONG_CYCLES+1) shall clear on btn_press, increment while btn_level=1, saturate at LONG_CYCLES; btn_long shall pulse once in the cycle the counter reaches LONG_CYCLES; release bounce (RELEASE_WAIT->HELD) shall not clear it.
REQ-029 Without the macro: no hold counter shall exist and btn_long shall be tied to 0.

Verification (SYNC_STAGES=2, DEB_CYCLES=4, LONG_CYCLES=10, 10 ns clk)
REQ-030 Reset: rst_n=0 with btn_in=1 -> all outputs 0 immediately; rst_n released with btn_in held 1 -> btn_press pulse 6 edges later, btn_level=1.
REQ-031 Clean press: btn_in 0->1 held 20 cycles -> single btn_press 6 edges after change, btn_level high thereafter, btn_release=0.
REQ-032 Bounce: btn_in high 3 cycles, low 1, high 3, low 1, then high steady -> no pulse until 6 edges after final rise; exactly one btn_press.
REQ-033 Release glitch: from HELD, btn_in low 3 cycles then high -> no btn_release, btn_level stays 1, no second btn_press; then low steady -> one btn_release 6 edges later.
REQ-034 Long press (macro on): hold 25 cycles -> btn_long single pulse 10 cycles after btn_press; macro off -> btn_long constant 0.
REQ-035 Reset mid-hold: assert rst_n in HELD for 3 cycles while btn_in=0 -> outputs 0 asynchronously, no btn_release or btn_long thereafter.
